// File: rtl/sine_voice_scheduler.sv
// Three-voice sine scheduler sharing one quarter-wave ROM; mixes one sample per request.
// Optional macro MIX_SATURATE_EN: clamp the mix instead of scaling it by 1/4.
module sine_voice_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_sample,
  input  logic [2:0]  voice_en,
  input  logic [24:0] step_size_0,
  input  logic [24:0] step_size_1,
  input  logic [24:0] step_size_2,
  output logic [9:0]  rom_addr,
  input  logic [15:0] rom_dout,
  output logic [15:0] sample,
  output logic        sample_ready,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StOutput} state_e;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [24:0]        phase_q [3];
  logic [24:0]        step [3];
  logic [24:0]        cur_phase;
  logic               cur_en;
  // Sign, enable and valid of the ROM read that lands this cycle.
  logic               sign_q, en_q, add_q;
  logic signed [17:0] acc_q, acc_d, rom_ext, contrib;
  logic [15:0]        mix;

  assign step[0] = step_size_0;
  assign step[1] = step_size_1;
  assign step[2] = step_size_2;

  always_comb begin
    cur_phase = '0;
    cur_en    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (idx_q == 2'(i)) begin
        cur_phase = phase_q[i];
        cur_en    = voice_en[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (new_sample) begin
          state_d = StFetch;
          idx_d   = 2'd0;
        end
      end
      StFetch: begin
        if (idx_q == 2'd2) state_d = StDrain;
        else               idx_d   = idx_q + 2'd1;
      end
      StDrain:  state_d = StOutput;
      StOutput: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rom_addr = '0;
    if (state_q == StFetch) begin
      rom_addr = cur_phase[20] ? ~cur_phase[19:10] : cur_phase[19:10];
    end
  end

  assign rom_ext = {{2{rom_dout[15]}}, rom_dout};

  always_comb begin
    contrib = '0;
    if (en_q) contrib = sign_q ? -rom_ext : rom_ext;
  end

  always_comb begin
    acc_d = acc_q;
    if (state_q == StIdle && new_sample) acc_d = '0;
    else if (add_q)                      acc_d = acc_q + contrib;
  end

`ifdef MIX_SATURATE_EN
  always_comb begin
    if (acc_d > 18'sd32767)       mix = 16'h7FFF;
    else if (acc_d < -18'sd32768) mix = 16'h8000;
    else                          mix = acc_d[15:0];
  end
`else
  assign mix = acc_d[17:2];
`endif

  assign sample_ready = (state_q == StOutput);
  assign busy         = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      en_q    <= 1'b0;
      add_q   <= 1'b0;
      sample  <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < 3; i++) phase_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sign_q  <= cur_phase[21];
      en_q    <= cur_en;
      add_q   <= (state_q == StFetch);
      if (state_q == StDrain) sample <= mix;
      if (new_sample && state_q != StIdle) overrun <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (state_q == StFetch && idx_q == 2'(i) && voice_en[i]) begin
          phase_q[i] <= phase_q[i] + step[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Directed bench for sine_voice_scheduler: index stepping, mirror/sign, mix, latency,
// overrun and reset abort, with hand-computed expectations.
module tb_sine_voice_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_sample;
  logic [2:0]  voice_en;
  logic [24:0] step_size_0, step_size_1, step_size_2;
  logic [9:0]  rom_addr;
  logic [15:0] rom_dout;
  logic [15:0] rom_val;
  logic [15:0] sample;
  logic        sample_ready, busy, overrun;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MIX_SATURATE_EN
  localparam logic [15:0] ExpPos1000 = 16'h1000;
  localparam logic [15:0] ExpNeg1000 = 16'hF000;
  localparam logic [15:0] ExpMix3    = 16'h7FFF;
  localparam logic [15:0] ExpMix2    = 16'h7FFF;
`else
  localparam logic [15:0] ExpPos1000 = 16'h0400;
  localparam logic [15:0] ExpNeg1000 = 16'hFC00;
  localparam logic [15:0] ExpMix3    = 16'h5FFF;
  localparam logic [15:0] ExpMix2    = 16'h3FFF;
`endif

  always #5 clk = ~clk;

  // ROM model: data for any address, one cycle after it is presented.
  always @(posedge clk) rom_dout <= rom_val;

  sine_voice_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .new_sample   (new_sample),
    .voice_en     (voice_en),
    .step_size_0  (step_size_0),
    .step_size_1  (step_size_1),
    .step_size_2  (step_size_2),
    .rom_addr     (rom_addr),
    .rom_dout     (rom_dout),
    .sample       (sample),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    new_sample = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One full request; expects addresses for FETCH(0..2) and the resulting sample.
  task automatic run_req(input string tag, input logic [9:0] a0, input logic [9:0] a1,
                         input logic [9:0] a2, input logic [15:0] exp_sample);
    new_sample = 1'b1;
    tick();
    new_sample = 1'b0;
    check_eq({tag, " addr0"}, 32'(rom_addr), 32'(a0));
    check_eq({tag, " busy"}, 32'(busy), 32'd1);
    tick();
    check_eq({tag, " addr1"}, 32'(rom_addr), 32'(a1));
    tick();
    check_eq({tag, " addr2"}, 32'(rom_addr), 32'(a2));
    tick();
    check_eq({tag, " drain addr"}, 32'(rom_addr), 32'd0);
    check_eq({tag, " drain ready"}, 32'(sample_ready), 32'd0);
    tick();
    check_eq({tag, " ready"}, 32'(sample_ready), 32'd1);
    check_eq({tag, " sample"}, 32'(sample), 32'(exp_sample));
    tick();
    check_eq({tag, " idle busy"}, 32'(busy), 32'd0);
    check_eq({tag, " idle ready"}, 32'(sample_ready), 32'd0);
    check_eq({tag, " held"}, 32'(sample), 32'(exp_sample));
    repeat (3) tick();
  endtask

  initial begin
    int ready_cnt;
    reset = 1'b1;
    new_sample = 1'b0;
    voice_en = 3'b000;
    step_size_0 = '0;
    step_size_1 = '0;
    step_size_2 = '0;
    rom_val = '0;
    do_reset();

    check_eq("rst sample", 32'(sample), 32'd0);
    check_eq("rst ready", 32'(sample_ready), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst overrun", 32'(overrun), 32'd0);
    check_eq("rst addr", 32'(rom_addr), 32'd0);

    // Index step: phase 0 -> 0x400 -> 0x800.
    voice_en = 3'b001;
    step_size_0 = 25'h400;
    run_req("idx1", 10'd0, 10'd0, 10'd0, 16'h0000);
    run_req("idx2", 10'd1, 10'd0, 10'd0, 16'h0000);
    run_req("idx3", 10'd2, 10'd0, 10'd0, 16'h0000);

    // Mirror/sign: phase 0x300000 mirrors the address and negates the data.
    do_reset();
    voice_en = 3'b001;
    step_size_0 = 25'h300000;
    rom_val = 16'h1000;
    run_req("mir1", 10'd0, 10'd0, 10'd0, ExpPos1000);
    run_req("mir2", 10'h3FF, 10'd0, 10'd0, ExpNeg1000);

    // Mix of full-scale voices.
    do_reset();
    voice_en = 3'b111;
    step_size_0 = '0;
    rom_val = 16'h7FFF;
    run_req("mix3", 10'd0, 10'd0, 10'd0, ExpMix3);
    voice_en = 3'b011;
    run_req("mix2", 10'd0, 10'd0, 10'd0, ExpMix2);

    // Latency and overrun: second request at T+2 is dropped.
    do_reset();
    voice_en = 3'b001;
    step_size_0 = 25'h400;
    rom_val = '0;
    new_sample = 1'b1;
    tick();
    new_sample = 1'b0;
    tick();
    new_sample = 1'b1;
    tick();
    new_sample = 1'b0;
    check_eq("ovr overrun T+3", 32'(overrun), 32'd1);
    tick();
    check_eq("ovr ready T+4", 32'(sample_ready), 32'd0);
    tick();
    check_eq("ovr ready T+5", 32'(sample_ready), 32'd1);
    tick();
    check_eq("ovr busy T+6", 32'(busy), 32'd0);
    ready_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (sample_ready || busy) ready_cnt++;
      tick();
    end
    check_eq("ovr no extra", 32'(ready_cnt), 32'd0);
    check_eq("ovr sticky", 32'(overrun), 32'd1);

    // Request during OUTPUT is also dropped.
    do_reset();
    check_eq("ovr cleared", 32'(overrun), 32'd0);
    new_sample = 1'b1;
    tick();
    new_sample = 1'b0;
    repeat (4) tick();
    check_eq("out ready", 32'(sample_ready), 32'd1);
    new_sample = 1'b1;
    tick();
    new_sample = 1'b0;
    check_eq("out overrun", 32'(overrun), 32'd1);
    check_eq("out busy", 32'(busy), 32'd0);

    // Reset abort at T+2, together with a new request that reset must override.
    do_reset();
    voice_en = 3'b001;
    step_size_0 = 25'h400;
    rom_val = 16'h1000;
    new_sample = 1'b1;
    tick();
    new_sample = 1'b0;
    tick();
    reset = 1'b1;
    new_sample = 1'b1;
    tick();
    reset = 1'b0;
    new_sample = 1'b0;
    ready_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (sample_ready || busy) ready_cnt++;
      tick();
    end
    check_eq("abort no ready", 32'(ready_cnt), 32'd0);
    check_eq("abort sample", 32'(sample), 32'd0);
    check_eq("abort overrun", 32'(overrun), 32'd0);
    rom_val = '0;
    run_req("abort idx1", 10'd0, 10'd0, 10'd0, 16'h0000);
    run_req("abort idx2", 10'd1, 10'd0, 10'd0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
